// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the main-memory burst arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_BURST_LEN = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit at or after ptr_i,
// wrapping around; returns it one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int   k;
    logic found;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    k        = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!found && vec_i[k]) begin
        found       = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing main memory among cache miss controllers.
// Define MEM_ARB_WB_PRIO_EN to let writebacks win over fill reads.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      mem_cmd_valid,
  output logic                      mem_cmd_wr,
  output logic [ADDR_W-1:0]         mem_cmd_addr,
  input  logic                      mem_cmd_ack,
  input  logic                      mem_beat,
  output logic                      busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;

  state_e              state_q, state_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  all_oh;
  logic [IW-1:0]       all_idx;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                last_beat;
  logic [IW-1:0]       rr_next;
  logic [NUM_REQ-1:0]  win_oh;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_all (
    .vec_i    (req),
    .ptr_i    (rr_q),
    .onehot_o (all_oh),
    .idx_o    (all_idx)
  );

`ifdef MEM_ARB_WB_PRIO_EN
  logic [NUM_REQ-1:0]  wb_vec;
  logic [NUM_REQ-1:0]  wb_oh;
  logic [IW-1:0]       wb_idx;

  assign wb_vec = req & req_wr;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_wb (
    .vec_i    (wb_vec),
    .ptr_i    (rr_q),
    .onehot_o (wb_oh),
    .idx_o    (wb_idx)
  );

  // a pending writeback frees its bank before any refill is issued
  assign pick_idx = (|wb_oh) ? wb_idx : all_idx;
`else
  assign pick_idx = all_idx;
`endif

  assign pick_any  = |all_oh;
  assign last_beat = (cnt_q == CW'(BURST_LEN - 1));
  assign rr_next   = (int'(win_q) == NUM_REQ - 1) ?
                     '0 : win_q + IW'(1);
  assign win_oh    = NUM_REQ'(1) << win_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          wr_d    = req_wr[pick_idx];
          addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (mem_cmd_ack) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (mem_beat) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        rr_d    = rr_next;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign gnt           = busy ? win_oh : '0;
  assign done          = (state_q == ST_DONE) ? win_oh : '0;
  assign mem_cmd_valid = (state_q == ST_CMD);
  assign mem_cmd_wr    = wr_q;
  assign mem_cmd_addr  = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of full bursts plus
// hand-written sequences for back-to-back, drop and mid-burst reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_wr;
  logic [95:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        mem_cmd_valid;
  logic        mem_cmd_wr;
  logic [23:0] mem_cmd_addr;
  logic        mem_cmd_ack;
  logic        mem_beat;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .gnt           (gnt),
    .done          (done),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_wr    (mem_cmd_wr),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_ack   (mem_cmd_ack),
    .mem_beat      (mem_beat),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  rw;
    int          ack;
    logic        cbeat;
    logic [3:0]  g;
    logic [23:0] a;
    logic        w;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic all_zero(input string nm);
    check({nm, "_gnt"}, 32'(gnt), 0);
    check({nm, "_done"}, 32'(done), 0);
    check({nm, "_valid"}, 32'(mem_cmd_valid), 0);
    check({nm, "_wr"}, 32'(mem_cmd_wr), 0);
    check({nm, "_addr"}, 32'(mem_cmd_addr), 0);
    check({nm, "_busy"}, 32'(busy), 0);
  endtask

  // Called at an IDLE-cycle negedge after req was driven.
  // Returns at the negedge of the IDLE cycle following DONE.
  task automatic do_burst(input logic [3:0] eg, input logic [23:0] ea,
                          input logic ew, input int ack_dly,
                          input logic cbeat, input int drop_beat,
                          input logic [3:0] drop_mask,
                          input logic drop_done);
    int   vcnt;
    logic early;
    @(negedge clk);
    check("cmd_valid", 32'(mem_cmd_valid), 1);
    check("cmd_gnt", 32'(gnt), 32'(eg));
    check("cmd_addr", 32'(mem_cmd_addr), 32'(ea));
    check("cmd_wr", 32'(mem_cmd_wr), 32'(ew));
    vcnt = 1;
    mem_beat = cbeat;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (mem_cmd_valid) vcnt++;
    end
    mem_cmd_ack = 1'b1;
    @(negedge clk);
    mem_cmd_ack = 1'b0;
    check("xfer_valid_low", 32'(mem_cmd_valid), 0);
    check("valid_cycles", 32'(vcnt), 32'(ack_dly + 1));
    early = 1'b0;
    for (int b = 0; b < 512; b++) begin
      mem_beat = 1'b1;
      if (b == drop_beat) req = req & ~drop_mask;
      if (done != 4'b0) early = 1'b1;
      @(negedge clk);
    end
    mem_beat = 1'b0;
    check("no_early_done", 32'(early), 0);
    check("done_pulse", 32'(done), 32'(eg));
    check("done_gnt", 32'(gnt), 32'(eg));
    if (drop_done) req = 4'b0;
    @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_gnt", 32'(gnt), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = 4'b0;
    req_wr      = 4'b0;
    req_addr    = {24'h001300, 24'h001200, 24'h001100, 24'h001000};
    mem_cmd_ack = 1'b0;
    mem_beat    = 1'b0;

    tbl[0] = '{4'b0001, 4'b0000, 2, 1'b0, 4'b0001, 24'h001000, 1'b0};
    tbl[1] = '{4'b0011, 4'b0011, 0, 1'b0, 4'b0010, 24'h001100, 1'b1};
    tbl[2] = '{4'b0011, 4'b0000, 1, 1'b1, 4'b0001, 24'h001000, 1'b0};
    tbl[3] = '{4'b1000, 4'b1000, 3, 1'b1, 4'b1000, 24'h001300, 1'b1};
    tbl[4] = '{4'b0110, 4'b0000, 0, 1'b0, 4'b0010, 24'h001100, 1'b0};
    tbl[5] = '{4'b1001, 4'b0000, 1, 1'b1, 4'b1000, 24'h001300, 1'b0};
`ifdef MEM_ARB_WB_PRIO_EN
    tbl[6] = '{4'b0101, 4'b0100, 0, 1'b0, 4'b0100, 24'h001200, 1'b1};
`else
    tbl[6] = '{4'b0101, 4'b0100, 0, 1'b0, 4'b0001, 24'h001000, 1'b0};
`endif

    #3;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // stray beats/acks while idle must not start anything
    mem_beat    = 1'b1;
    mem_cmd_ack = 1'b1;
    repeat (3) @(negedge clk);
    mem_beat    = 1'b0;
    mem_cmd_ack = 1'b0;
    check("idle_stray_busy", 32'(busy), 0);
    check("idle_stray_valid", 32'(mem_cmd_valid), 0);

    for (int v = 0; v < 7; v++) begin
      req    = tbl[v].rq;
      req_wr = tbl[v].rw;
      do_burst(tbl[v].g, tbl[v].a, tbl[v].w, tbl[v].ack,
               tbl[v].cbeat, -1, 4'b0, 1'b1);
    end

    // back-to-back: all four requesting, round-robin from pointer 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    req_wr = 4'b0;
    req    = 4'b1111;
    do_burst(4'b0001, 24'h001000, 1'b0, 0, 1'b0, -1, 4'b0, 1'b0);
    do_burst(4'b0010, 24'h001100, 1'b0, 0, 1'b0, -1, 4'b0, 1'b0);
    do_burst(4'b0100, 24'h001200, 1'b0, 1, 1'b0, -1, 4'b0, 1'b0);
    do_burst(4'b1000, 24'h001300, 1'b0, 0, 1'b0, -1, 4'b0, 1'b0);
    do_burst(4'b0001, 24'h001000, 1'b0, 0, 1'b0, -1, 4'b0, 1'b0);
    req = 4'b0;

    // requester 1 drops req at beat 100
    req = 4'b0010;
    do_burst(4'b0010, 24'h001100, 1'b0, 0, 1'b0, 100, 4'b0010, 1'b0);
    @(negedge clk);
    check("drop_stays_idle", 32'(busy), 0);

    // reset during beat 300 of a burst
    req = 4'b0100;
    @(negedge clk);
    check("rst_seq_gnt", 32'(gnt), 32'(4'b0100));
    mem_cmd_ack = 1'b1;
    @(negedge clk);
    mem_cmd_ack = 1'b0;
    for (int b = 0; b < 300; b++) begin
      mem_beat = 1'b1;
      @(negedge clk);
    end
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("midrst");
    mem_beat = 1'b0;
    req      = 4'b0;
    @(negedge clk);
    check("midrst_no_done", 32'(done), 0);
    rst_n = 1'b1;
    req   = 4'b0110;
    do_burst(4'b0010, 24'h001100, 1'b0, 0, 1'b0, -1, 4'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
